ah_pl2ddr_burst_scheduler: RTL and testbench

Sequences the AXI write-burst master of the PL-to-DDR pipeline.
- Watches the BRAM fill level and picks each burst length.
- Walks the DDR write address through the configured window.
- Fires one transaction request per burst and tracks completion, timeout and error.
- Sits between the command FSM (config and enable) and the AXI master (INIT/DONE/ERROR).

---
 rtl/ah_pl2ddr_pkg.sv | 15 +
 rtl/ah_pl2ddr_burst_len_calc.sv | 26 ++
 rtl/ah_pl2ddr_burst_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ah_pl2ddr_burst_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_pl2ddr_pkg.sv
// ah_pl2ddr_pkg: shared FSM state codes, AXI 4 KiB boundary constant and a min helper
package ah_pl2ddr_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_ADVANCE = 3'd4,
      S_HALT    = 3'd5
   } state_e;
   localparam int unsigned AXI_4K_BYTES = 4096;
   function automatic logic [32:0] min2(input logic [32:0] a, input logic [32:0] b);
      return (a < b) ? a : b;
   endfunction
endpackage

// File: rtl/ah_pl2ddr_burst_len_calc.sv
// ah_pl2ddr_burst_len_calc: combinational burst length from fill level, 4 KiB page and window end
module ah_pl2ddr_burst_len_calc
   import ah_pl2ddr_pkg::*;
#(
   parameter int unsigned BEAT_BYTES    = 4,
   parameter int unsigned MAX_BURST_LEN = 256,
   parameter int unsigned AVAIL_WIDTH   = 10
) (
   input  logic [31:0]            addr,
   input  logic [31:0]            high,
   input  logic [AVAIL_WIDTH-1:0] avail,
   output logic [8:0]             len,
   output logic                   high_zero,
   output logic                   clamped
);
   localparam int SH = $clog2(BEAT_BYTES);
   logic [32:0] to_high, to_4k, bound, pick;
   // 33 bits so a window ending at 0xFFFFFFFF still yields a correct distance
   assign to_high   = ({1'b0, high} + 33'd1 - {1'b0, addr}) >> SH;
   assign to_4k     = (33'(AXI_4K_BYTES) - {21'b0, addr[11:0]}) >> SH;
   assign bound     = min2(to_4k, to_high);
   assign pick      = min2(min2(33'(avail), 33'(MAX_BURST_LEN)), bound);
   assign len       = 9'(pick);
   assign high_zero = to_high == 33'd0;
   assign clamped   = pick != 33'd0 && pick == bound;
endmodule

// File: rtl/ah_pl2ddr_burst_scheduler.sv
// ah_pl2ddr_burst_scheduler: sizes and sequences AXI write bursts through a DDR address window.
// AH_PL2DDR_SCHED_WRAP_EN: wrap back to the window start instead of halting when it is exhausted.
module ah_pl2ddr_burst_scheduler
   import ah_pl2ddr_pkg::*;
#(
   parameter int unsigned BEAT_BYTES     = 4,
   parameter int unsigned MAX_BURST_LEN  = 256,
   parameter int unsigned MIN_BURST_LEN  = 16,
   parameter int unsigned AVAIL_WIDTH    = 10,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   flush,
   input  logic [31:0]            ddr_addr_low,
   input  logic [31:0]            ddr_addr_high,
   input  logic [AVAIL_WIDTH-1:0] data_available,
   input  logic                   transfer_en,
   input  logic                   axi_tx_done,
   input  logic                   axi_error,
   output logic                   out_tx_init,
   output logic [31:0]            out_ddr_addr,
   output logic [8:0]             out_burst_len,
   output logic [10:0]            out_burst_number,
   output logic [31:0]            bursts_done,
   output logic [31:0]            bytes_transmitted,
   output logic                   busy,
   output logic                   window_full,
   output logic                   error,
   output logic [2:0]             state
);
   localparam int SH = $clog2(BEAT_BYTES);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   state_e      state_q, state_d;
   logic        en_q, en_d, wf_q, wf_d, err_q, err_d;
   logic [31:0] low_q, low_d, high_q, high_d, addr_q, addr_d, daddr_q, daddr_d;
   logic [31:0] bursts_q, bursts_d, bytes_q, bytes_d, tmo_q, tmo_d, step;
   logic [8:0]  len_q, len_d, calc_len;
   logic        at_high, clamped;

   ah_pl2ddr_burst_len_calc #(
      .BEAT_BYTES   (BEAT_BYTES),
      .MAX_BURST_LEN(MAX_BURST_LEN),
      .AVAIL_WIDTH  (AVAIL_WIDTH)
   ) u_len (
      .addr     (addr_q),
      .high     (high_q),
      .avail    (data_available),
      .len      (calc_len),
      .high_zero(at_high),
      .clamped  (clamped)
   );

   assign step = 32'(len_q) << SH;

   always_comb begin
      state_d  = state_q;
      en_d     = enable;
      low_d    = low_q;
      high_d   = high_q;
      addr_d   = addr_q;
      daddr_d  = daddr_q;
      len_d    = len_q;
      bursts_d = bursts_q;
      bytes_d  = bytes_q;
      wf_d     = wf_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_IDLE: if (enable && !en_q) begin
            low_d   = ddr_addr_low;
            high_d  = ddr_addr_high;
            addr_d  = ddr_addr_low;
            state_d = S_CHECK;
         end
         S_CHECK: if (!enable) state_d = S_IDLE;
         else if (transfer_en) begin
            if (at_high) begin
               wf_d = 1'b1;
`ifdef AH_PL2DDR_SCHED_WRAP_EN
               addr_d = low_q;
`else
               state_d = S_HALT;
`endif
            end else if (calc_len >= 9'(MIN_BURST_LEN) || (flush && calc_len != 9'd0) || clamped) begin
               len_d   = calc_len;
               daddr_d = addr_q;
               tmo_d   = 32'd0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tmo_d   = tmo_q + 32'd1;
            state_d = S_WAIT;
         end
         // the count includes the ISSUE cycle, so HALT lands TIMEOUT_CYCLES cycles after the request
         S_WAIT: begin
            tmo_d = tmo_q + 32'd1;
            if (axi_tx_done) state_d = S_ADVANCE;
            else if (TIMEOUT_CYCLES != 0 && tmo_q >= TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end
         end
         S_ADVANCE: begin
            addr_d   = addr_q + step;
            bursts_d = bursts_q + 32'd1;
            bytes_d  = bytes_q + step;
            state_d  = S_CHECK;
         end
         default: ;
      endcase
      if (axi_error && state_q != S_IDLE && state_q != S_HALT) begin
         err_d   = 1'b1;
         state_d = S_HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         en_q     <= 1'b0;
         low_q    <= '0;
         high_q   <= '0;
         addr_q   <= '0;
         daddr_q  <= '0;
         len_q    <= '0;
         bursts_q <= '0;
         bytes_q  <= '0;
         wf_q     <= 1'b0;
         err_q    <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         low_q    <= low_d;
         high_q   <= high_d;
         addr_q   <= addr_d;
         daddr_q  <= daddr_d;
         len_q    <= len_d;
         bursts_q <= bursts_d;
         bytes_q  <= bytes_d;
         wf_q     <= wf_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign out_tx_init       = state_q == S_ISSUE;
   assign out_ddr_addr      = daddr_q;
   assign out_burst_len     = len_q;
   assign out_burst_number  = 11'd1;
   assign bursts_done       = bursts_q;
   assign bytes_transmitted = bytes_q;
   assign busy              = state_q != S_IDLE;
   assign window_full       = wf_q;
   assign error             = err_q;
   assign state             = state_q;
endmodule

// File: tb/tb_ah_pl2ddr_burst_scheduler.sv
// tb_ah_pl2ddr_burst_scheduler: directed plus randomized bursts scored against an arithmetic window model
module tb_ah_pl2ddr_burst_scheduler;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, flush = 1'b0, transfer_en = 1'b0;
   logic        axi_tx_done = 1'b0, axi_error = 1'b0;
   logic [31:0] ddr_addr_low = '0, ddr_addr_high = '0;
   logic [9:0]  data_available = '0;
   logic        out_tx_init, busy, window_full, error;
   logic [31:0] out_ddr_addr, bursts_done, bytes_transmitted;
   logic [8:0]  out_burst_len;
   logic [10:0] out_burst_number;
   logic [2:0]  state;

   int          checks = 0, errors = 0, init_cnt = 0, init_cyc = 0, cyc = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_addr, m_low, m_high, m_bursts, m_bytes;
   bit          m_wf, halted;

   ah_pl2ddr_burst_scheduler #(.TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .ddr_addr_low(ddr_addr_low), .ddr_addr_high(ddr_addr_high),
      .data_available(data_available), .transfer_en(transfer_en),
      .axi_tx_done(axi_tx_done), .axi_error(axi_error),
      .out_tx_init(out_tx_init), .out_ddr_addr(out_ddr_addr),
      .out_burst_len(out_burst_len), .out_burst_number(out_burst_number),
      .bursts_done(bursts_done), .bytes_transmitted(bytes_transmitted),
      .busy(busy), .window_full(window_full), .error(error), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: every request pulse must match the oldest predicted burst
   always @(negedge clk) if (rst === 1'b0 && out_tx_init === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_init", {32'b0, out_ddr_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
         logic [63:0] e;
         e = exp_q.pop_front();
         chk("burst_addr", {32'b0, out_ddr_addr}, {32'b0, e[63:32]});
         chk("burst_len", {55'b0, out_burst_len}, {32'b0, e[31:0]});
         chk("burst_number", {53'b0, out_burst_number}, 64'd1);
      end
      init_cnt++;
      init_cyc = cyc;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input string name);
      int n = 0;
      while (state !== s && n < 300) begin
         tick();
         n++;
      end
      chk(name, {61'b0, state}, {61'b0, s});
   endtask

   // next burst from the window rules: fill level, 256 cap, distance to 4 KiB page and to window end
   function automatic void model(input logic [31:0] a, input logic [31:0] h, input int av, input bit fl,
                                 output int len, output bit bth0, output bit issue);
      longint bth = (longint'(h) + 1 - longint'(a)) / 4;
      longint b4k = (4096 - longint'(a) % 4096) / 4;
      longint l = av;
      if (l > 256) l = 256;
      if (l > b4k) l = b4k;
      if (l > bth) l = bth;
      len = int'(l);
      bth0 = bth == 0;
      issue = !bth0 && (l >= 16 || (fl && l > 0) || (l > 0 && (l == b4k || l == bth)));
   endfunction

   task automatic check_reset();
      chk("rst_state", {61'b0, state}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_init", {63'b0, out_tx_init}, 64'd0);
      chk("rst_addr", {32'b0, out_ddr_addr}, 64'd0);
      chk("rst_len", {55'b0, out_burst_len}, 64'd0);
      chk("rst_burst_number", {53'b0, out_burst_number}, 64'd1);
      chk("rst_bursts", {32'b0, bursts_done}, 64'd0);
      chk("rst_bytes", {32'b0, bytes_transmitted}, 64'd0);
      chk("rst_wfull", {63'b0, window_full}, 64'd0);
      chk("rst_error", {63'b0, error}, 64'd0);
   endtask

   task automatic restart(input logic [31:0] lo, input logic [31:0] hi, input bit do_rst);
      enable = 0; transfer_en = 0; flush = 0; axi_tx_done = 0; axi_error = 0;
      if (do_rst) begin
         rst = 1;
         tick();
         rst = 0;
         m_bursts = 0; m_bytes = 0; m_wf = 0;
      end
      tick();
      ddr_addr_low = lo; ddr_addr_high = hi; enable = 1;
      tick();
      wait_state(3'd1, "enter_check");
      ddr_addr_low = 32'hDEAD_BEE0; ddr_addr_high = 32'h0000_0010;
      m_addr = lo; m_low = lo; m_high = hi; halted = 0;
   endtask

   task automatic start_burst(input int av, input bit fl, output int len);
      bit bth0, issue;
      int n0, n;
      data_available = 10'(av);
      flush = fl;
      len = 0;
      model(m_addr, m_high, av, fl, len, bth0, issue);
      if (bth0) begin
`ifdef AH_PL2DDR_SCHED_WRAP_EN
         m_addr = m_low;
         m_wf = 1;
         model(m_addr, m_high, av, fl, len, bth0, issue);
`else
         n0 = init_cnt;
         transfer_en = 1;
         repeat (20) tick();
         chk("end_halt_state", {61'b0, state}, 64'd5);
         chk("end_halt_wfull", {63'b0, window_full}, 64'd1);
         chk("end_halt_error", {63'b0, error}, 64'd0);
         chk("end_halt_no_init", 64'(init_cnt), 64'(n0));
         transfer_en = 0;
         halted = 1;
         len = 0;
         return;
`endif
      end
      if (!issue) begin
         n0 = init_cnt;
         transfer_en = 1;
         repeat (100) tick();
         chk("short_no_init", 64'(init_cnt), 64'(n0));
         transfer_en = 0;
         flush = 1;
         if (av == 0) av = 1;
         data_available = 10'(av);
         model(m_addr, m_high, av, 1'b1, len, bth0, issue);
      end
      exp_q.push_back({m_addr, 32'(len)});
      n0 = init_cnt;
      n = 0;
      transfer_en = 1;
      while (init_cnt == n0 && n < 100) begin
         tick();
         n++;
      end
      chk("init_seen", 64'(init_cnt != n0), 64'd1);
      transfer_en = 0;
   endtask

   task automatic do_burst(input int av, input bit fl, input int dly);
      int len;
      start_burst(av, fl, len);
      if (halted) return;
      repeat (dly) tick();
      axi_tx_done = 1;
      tick();
      axi_tx_done = 0;
      m_addr += 32'(len) * 4;
      m_bursts += 1;
      m_bytes += 32'(len) * 4;
      wait_state(3'd1, "back_to_check");
      chk("bursts_done", {32'b0, bursts_done}, {32'b0, m_bursts});
      chk("bytes_tx", {32'b0, bytes_transmitted}, {32'b0, m_bytes});
      chk("wfull", {63'b0, window_full}, {63'b0, m_wf});
      chk("no_error", {63'b0, error}, 64'd0);
   endtask

   initial begin
      int len, n0, k;
      logic [31:0] lo;
      m_bursts = 0; m_bytes = 0; m_wf = 0; halted = 0;
      repeat (3) tick();
      check_reset();
      rst = 0;
      restart(32'h0010_0000, 32'h0010_0FFF, 0);
      do_burst(300, 0, 3);
      do_burst(44, 0, 3);
      chk("p1_bursts", {32'b0, bursts_done}, 64'd2);
      chk("p1_bytes", {32'b0, bytes_transmitted}, 64'd1200);
      restart(32'h0010_0FC0, 32'h0010_1FFF, 0);
      do_burst(256, 0, 1);
      do_burst(5, 0, 2);
      restart(32'h0020_0000, 32'h0020_03FF, 1);
      do_burst(256, 0, 2);
      do_burst(256, 0, 2);
      chk("p4_wfull", {63'b0, window_full}, 64'd1);
      // timeout: no done ever arrives
      restart(32'h0040_0000, 32'h0040_FFFF, 1);
      start_burst(64, 0, len);
      k = 0;
      while (cyc < init_cyc + 49 && k < 200) begin
         tick();
         k++;
      end
      chk("tmo_pre_state", {61'b0, state}, 64'd3);
      chk("tmo_pre_error", {63'b0, error}, 64'd0);
      tick();
      chk("tmo_state", {61'b0, state}, 64'd5);
      chk("tmo_error", {63'b0, error}, 64'd1);
      // error pulse while waiting, and halt stays sticky
      restart(32'h0040_0000, 32'h0040_FFFF, 1);
      start_burst(64, 0, len);
      repeat (2) tick();
      axi_error = 1;
      tick();
      axi_error = 0;
      chk("err_state", {61'b0, state}, 64'd5);
      chk("err_flag", {63'b0, error}, 64'd1);
      n0 = init_cnt;
      transfer_en = 1;
      repeat (20) tick();
      chk("err_no_init", 64'(init_cnt), 64'(n0));
      chk("err_sticky", {61'b0, state}, 64'd5);
      // done and error together: error wins
      restart(32'h0040_0000, 32'h0040_FFFF, 1);
      start_burst(64, 0, len);
      axi_tx_done = 1;
      axi_error = 1;
      tick();
      axi_tx_done = 0;
      axi_error = 0;
      chk("both_state", {61'b0, state}, 64'd5);
      chk("both_error", {63'b0, error}, 64'd1);
      chk("both_bursts", {32'b0, bursts_done}, 64'd0);
      // reset in the middle of a burst
      restart(32'h0040_0000, 32'h0040_FFFF, 1);
      start_burst(64, 0, len);
      tick();
      rst = 1;
      enable = 0;
      tick();
      check_reset();
      rst = 0;
      m_bursts = 0; m_bytes = 0; m_wf = 0;
      restart(32'h0050_0100, 32'h005F_FFFF, 0);
      do_burst(32, 0, 1);
      // randomized windows and fill levels
      for (int i = 0; i < 40; i++) begin
         if (halted || i % 10 == 0) begin
            lo = 32'h0030_0000 + 32'($urandom_range(0, 1023)) * 4;
            restart(lo, lo + 32'($urandom_range(40, 9000)) - 1, 1);
         end
         case ($urandom_range(0, 2))
            0: do_burst(int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            1: do_burst(int'($urandom_range(0, 1023)), 1'b0, int'($urandom_range(0, 6)));
            default: do_burst(int'($urandom_range(100, 400)), 1'b0, int'($urandom_range(0, 6)));
         endcase
      end
      repeat (5) tick();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
